// File: rtl/dense_sched_pkg.sv
// Shared types and constants for the dense-layer scheduler.
package dense_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FWD     = 3'd1,
        S_DRAIN_F = 3'd2,
        S_BWD     = 3'd3,
        S_DRAIN_B = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam int unsigned DENSE_FWD = 0;
    localparam int unsigned DENSE_BWD = 1;

endpackage

// File: rtl/inflight_counter.sv
// Outstanding-operation counter: saturates at both ends, flags underflow.
module inflight_counter #(
    parameter int unsigned max_inflight = 15
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                inc,
    input  logic                                dec,
    output logic [$clog2(max_inflight + 1)-1:0] count,
    output logic                                full,
    output logic                                empty,
    output logic                                underflow
);

    localparam int unsigned CNT_W = $clog2(max_inflight + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q, underflow_q;

    // Next count: simultaneous inc and dec cancel; both ends saturate.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != CNT_W'(max_inflight))) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count and status flags, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= (count_d == CNT_W'(max_inflight));
            empty_q     <= (count_d == '0);
            underflow_q <= dec && (count_q == '0);
        end
    end

    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/dense_layer_scheduler.sv
// Walks layers/rows for forward (and optional backward) passes, issuing one
// row op per accepted cycle and draining each layer before the next starts.
module dense_layer_scheduler
    import dense_sched_pkg::*;
#(
    parameter int unsigned max_layers      = 8,
    parameter int unsigned row_w           = 16,
    parameter int unsigned max_inflight    = 15,
    parameter int unsigned dense_type_size = 4,
    parameter int unsigned act_type_size   = 4,
    parameter int unsigned cost_type_size  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_we,
    input  logic [$clog2(max_layers)-1:0]   cfg_addr,
    input  logic [row_w-1:0]                cfg_rows,
    input  logic [$clog2(max_layers):0]     num_layers,
    input  logic                            train,
    input  logic [act_type_size-1:0]        act_type,
    input  logic [cost_type_size-1:0]       cost_type,
    input  logic                            start,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [31:0]                     w_layer_index,
    output logic [31:0]                     w_row_index,
    output logic [dense_type_size-1:0]      dense_type,
    output logic                            is_update,
    output logic                            backprop_cost,
    output logic                            is_cost_layer,
    output logic [act_type_size-1:0]        act_type_out,
    output logic [cost_type_size-1:0]       cost_type_out,
    input  logic                            result_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            err_underflow
);

    localparam int unsigned LAYER_W = $clog2(max_layers);
    localparam int unsigned NL_W    = LAYER_W + 1;
    localparam int unsigned CNT_W   = $clog2(max_inflight + 1);

    state_e                      state_q, state_d;
    logic [LAYER_W-1:0]          layer_q, layer_d;
    logic [row_w-1:0]            row_q, row_d;
    logic [NL_W-1:0]             nlayers_q, nlayers_d;
    logic                        train_q, train_d;
    logic [act_type_size-1:0]    act_q, act_d;
    logic [cost_type_size-1:0]   cost_q, cost_d;
    logic [row_w-1:0]            rows_q [max_layers];
    logic                        issue_valid_q, issue_valid_d;
    logic [dense_type_size-1:0]  dense_type_q, dense_type_d;
    logic                        is_update_q, is_update_d;
    logic                        backprop_cost_q, backprop_cost_d;
    logic                        is_cost_layer_q, is_cost_layer_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;

    logic                        accept;
    logic                        full_next;
    logic                        last_layer_next;
    logic                        fwd_next, bwd_next;
    logic [CNT_W-1:0]            inflight;
    logic                        inflight_full, inflight_empty, inflight_underflow;

    assign accept = issue_valid_q && issue_ready;

    // Will the counter sit at the limit after this edge? Gates the next issue.
    assign full_next = (inflight_full && !result_valid) ||
                       ((inflight == CNT_W'(max_inflight - 1)) && accept && !result_valid);

    inflight_counter #(
        .max_inflight (max_inflight)
    ) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .inc       (accept),
        .dec       (result_valid),
        .count     (inflight),
        .full      (inflight_full),
        .empty     (inflight_empty),
        .underflow (inflight_underflow)
    );

    // Row-count table; writes only land while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < max_layers; i++) rows_q[i] <= '0;
        end else if (cfg_we && (state_q == S_IDLE)) begin
            rows_q[cfg_addr] <= cfg_rows;
        end
    end

    // Next-state, walk position and registered issue bundle.
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        row_d     = row_q;
        nlayers_d = nlayers_q;
        train_d   = train_q;
        act_d     = act_q;
        cost_d    = cost_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nlayers_d = num_layers;
                    train_d   = train;
                    act_d     = act_type;
                    cost_d    = cost_type;
                    layer_d   = '0;
                    row_d     = '0;
                    err_d     = 1'b0;
                    state_d   = (num_layers == '0) ? S_DONE : S_FWD;
                end
            end
            S_FWD, S_BWD: begin
                if (accept) row_d = row_q + row_w'(1);
                if (row_d >= rows_q[layer_q]) begin
                    state_d = (state_q == S_FWD) ? S_DRAIN_F : S_DRAIN_B;
                end
            end
            S_DRAIN_F: begin
                if (inflight_empty) begin
                    row_d = '0;
                    if ((NL_W'(layer_q) + NL_W'(1)) < nlayers_q) begin
                        layer_d = layer_q + LAYER_W'(1);
                        state_d = S_FWD;
                    end else if (train_q) begin
                        layer_d = LAYER_W'(nlayers_q - NL_W'(1));
                        state_d = S_BWD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN_B: begin
                if (inflight_empty) begin
                    row_d = '0;
                    if (layer_q != '0) begin
                        layer_d = layer_q - LAYER_W'(1);
                        state_d = S_BWD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (inflight_underflow) err_d = 1'b1;

        fwd_next        = (state_d == S_FWD);
        bwd_next        = (state_d == S_BWD);
        last_layer_next = ((NL_W'(layer_d) + NL_W'(1)) == nlayers_d);
        issue_valid_d   = (fwd_next || bwd_next) && (row_d < rows_q[layer_d]) && !full_next;
        dense_type_d    = bwd_next ? dense_type_size'(DENSE_BWD) : dense_type_size'(DENSE_FWD);
        is_update_d     = bwd_next && train_d;
        backprop_cost_d = bwd_next && last_layer_next;
        is_cost_layer_d = fwd_next && train_d && last_layer_next;
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_q == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            layer_q         <= '0;
            row_q           <= '0;
            nlayers_q       <= '0;
            train_q         <= 1'b0;
            act_q           <= '0;
            cost_q          <= '0;
            issue_valid_q   <= 1'b0;
            dense_type_q    <= '0;
            is_update_q     <= 1'b0;
            backprop_cost_q <= 1'b0;
            is_cost_layer_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            layer_q         <= layer_d;
            row_q           <= row_d;
            nlayers_q       <= nlayers_d;
            train_q         <= train_d;
            act_q           <= act_d;
            cost_q          <= cost_d;
            issue_valid_q   <= issue_valid_d;
            dense_type_q    <= dense_type_d;
            is_update_q     <= is_update_d;
            backprop_cost_q <= backprop_cost_d;
            is_cost_layer_q <= is_cost_layer_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign issue_valid   = issue_valid_q;
    assign w_layer_index = 32'(layer_q);
    assign w_row_index   = 32'(row_q);
    assign dense_type    = dense_type_q;
    assign is_update     = is_update_q;
    assign backprop_cost = backprop_cost_q;
    assign is_cost_layer = is_cost_layer_q;
    assign act_type_out  = act_q;
    assign cost_type_out = cost_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_dense_layer_scheduler.sv
// Scoreboard bench for dense_layer_scheduler: expected issues are queued by
// the stimulus, a negedge monitor pops and compares every accepted issue.
module tb_dense_layer_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_rows;
    logic [3:0]  num_layers;
    logic        train;
    logic [3:0]  act_type;
    logic [7:0]  cost_type;
    logic        start;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] w_layer_index;
    logic [31:0] w_row_index;
    logic [3:0]  dense_type;
    logic        is_update;
    logic        backprop_cost;
    logic        is_cost_layer;
    logic [3:0]  act_type_out;
    logic [7:0]  cost_type_out;
    logic        result_valid;
    logic        busy;
    logic        done;
    logic        err_underflow;

    always #5 clk = ~clk;

    dense_layer_scheduler #(
        .max_layers(8), .row_w(16), .max_inflight(15),
        .dense_type_size(4), .act_type_size(4), .cost_type_size(8)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_rows(cfg_rows), .num_layers(num_layers), .train(train),
        .act_type(act_type), .cost_type(cost_type), .start(start),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .w_layer_index(w_layer_index), .w_row_index(w_row_index),
        .dense_type(dense_type), .is_update(is_update),
        .backprop_cost(backprop_cost), .is_cost_layer(is_cost_layer),
        .act_type_out(act_type_out), .cost_type_out(cost_type_out),
        .result_valid(result_valid), .busy(busy), .done(done),
        .err_underflow(err_underflow)
    );

    typedef struct packed {
        logic [31:0] layer;
        logic [31:0] row;
        logic [3:0]  dt;
        logic        upd;
        logic        bp;
        logic        cl;
    } iss_t;

    iss_t exp_q[$];
    int   pend[$];
    int   cfg_m[8];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_acc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   model_out = 0;
    int   start_cyc = 0;
    int   base = 0;
    logic hold_res = 1'b0;
    logic force_res = 1'b0;
    logic prev_stall = 1'b0;
    logic have_prev = 1'b0;
    iss_t held;
    iss_t prev_iss;
    iss_t mon_e;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic iss_t dut_iss();
        iss_t v;
        v.layer = w_layer_index;
        v.row   = w_row_index;
        v.dt    = dense_type;
        v.upd   = is_update;
        v.bp    = backprop_cost;
        v.cl    = is_cost_layer;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every accepted issue against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) chk("stall_hold", {issue_valid, dut_iss()}, {1'b1, held});
            if (issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got layer=%0d row=%0d want none",
                             w_layer_index, w_row_index);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue", dut_iss(), mon_e);
                end
                if (have_prev && (w_layer_index != prev_iss.layer || dense_type != prev_iss.dt))
                    chk("drained_before_next_layer", model_out, 0);
                prev_iss  = dut_iss();
                have_prev = 1'b1;
                model_out++;
                pend.push_back(cyc + 4);
                n_acc++;
            end
            prev_stall = issue_valid && !issue_ready;
            if (issue_valid) held = dut_iss();
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Pipeline model: return each result 4 cycles after acceptance.
    always @(posedge clk) begin
        int tmp;
        #2;
        if (reset) begin
            result_valid = 1'b0;
        end else if (force_res || (!hold_res && pend.size() > 0 && pend[0] <= cyc)) begin
            result_valid = 1'b1;
            if (pend.size() > 0) begin
                tmp = pend.pop_front();
                model_out--;
            end
        end else begin
            result_valid = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(int a, int r);
        cfg_we   = 1'b1;
        cfg_addr = 3'(a);
        cfg_rows = 16'(r);
        cfg_m[a] = r;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic push(int l, int r, int dt, bit u, bit b, bit c);
        iss_t e;
        e.layer = 32'(l);
        e.row   = 32'(r);
        e.dt    = 4'(dt);
        e.upd   = u;
        e.bp    = b;
        e.cl    = c;
        exp_q.push_back(e);
    endtask

    task automatic gen_exp(int nl, bit tr);
        for (int l = 0; l < nl; l++)
            for (int r = 0; r < cfg_m[l]; r++)
                push(l, r, 0, 1'b0, 1'b0, tr && (l == nl - 1));
        if (tr)
            for (int l = nl - 1; l >= 0; l--)
                for (int r = 0; r < cfg_m[l]; r++)
                    push(l, r, 1, 1'b1, l == nl - 1, 1'b0);
    endtask

    task automatic do_start(int nl, bit tr);
        num_layers = 4'(nl);
        train      = tr;
        start      = 1'b1;
        start_cyc  = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(int target, int bound, bit toggle);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            if (toggle) issue_ready = ~issue_ready;
            tick();
            n++;
        end
        issue_ready = 1'b1;
        chk("done_seen", done_cnt, target);
        repeat (4) tick();
        chk("done_once", done_cnt, target);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_rows = '0;
        num_layers = '0; train = 1'b0; act_type = '0; cost_type = '0;
        start = 1'b0; issue_ready = 1'b1; result_valid = 1'b0;
        for (int i = 0; i < 8; i++) cfg_m[i] = 0;
        #1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", {issue_valid, busy, done, err_underflow, is_update, backprop_cost,
                              is_cost_layer, dense_type, w_layer_index, w_row_index,
                              act_type_out, cost_type_out}, 0);
        tick();
        reset = 1'b0;
        tick();

        // Inference, rows {3,2}; also stray start and table write while busy.
        cfg(0, 3);
        cfg(1, 2);
        gen_exp(2, 1'b0);
        base      = n_acc;
        act_type  = 4'h5;
        cost_type = 8'hA3;
        do_start(2, 1'b0);
        act_type  = 4'h0;
        cost_type = 8'h00;
        tick();
        chk("latched_types", {act_type_out, cost_type_out}, {4'h5, 8'hA3});
        chk("busy_running", busy, 1);
        do_start(1, 1'b1);
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_rows = 16'd7;
        tick();
        cfg_we = 1'b0;
        wait_done(1, 300, 1'b0);
        chk("infer_issue_count", n_acc - base, 5);
        chk("idle_after_done", busy, 0);

        // Training, same table.
        gen_exp(2, 1'b1);
        base = n_acc;
        do_start(2, 1'b1);
        wait_done(2, 400, 1'b0);
        chk("train_issue_count", n_acc - base, 10);

        // Training with ready toggling every cycle.
        gen_exp(2, 1'b1);
        base = n_acc;
        do_start(2, 1'b1);
        wait_done(3, 800, 1'b1);
        chk("toggle_issue_count", n_acc - base, 10);

        // Inflight limit with results withheld, then accept+result same cycle.
        cfg(0, 20);
        hold_res = 1'b1;
        gen_exp(1, 1'b0);
        base = n_acc;
        do_start(1, 1'b0);
        repeat (30) tick();
        chk("limit_accepts", n_acc - base, 15);
        chk("limit_valid_low", issue_valid, 0);
        force_res = 1'b1;
        repeat (3) tick();
        force_res = 1'b0;
        repeat (6) tick();
        chk("same_cycle_accepts", n_acc - base, 18);
        chk("limit_valid_low2", issue_valid, 0);
        hold_res = 1'b0;
        wait_done(4, 300, 1'b0);
        chk("limit_total", n_acc - base, 20);

        // Reset mid-forward with 3 in flight.
        cfg(0, 10);
        hold_res = 1'b1;
        gen_exp(1, 1'b0);
        base = n_acc;
        do_start(1, 1'b0);
        for (int n = 0; n < 50 && (n_acc - base) < 3; n++) tick();
        chk("pre_reset_accepts", n_acc - base, 3);
        issue_ready = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        pend.delete();
        model_out = 0;
        for (int i = 0; i < 8; i++) cfg_m[i] = 0;
        tick();
        reset = 1'b0;
        hold_res = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {issue_valid, busy, done, err_underflow, is_update, backprop_cost,
                              is_cost_layer, dense_type, w_layer_index, w_row_index,
                              act_type_out, cost_type_out}, 0);
        tick();
        issue_ready = 1'b1;
        force_res = 1'b1;
        tick();
        force_res = 1'b0;
        repeat (3) tick();
        chk("underflow_set", err_underflow, 1);
        repeat (3) tick();
        chk("underflow_sticky", err_underflow, 1);

        // Zero layers: done two cycles after start, no issues, error cleared.
        base = n_acc;
        do_start(0, 1'b0);
        wait_done(5, 20, 1'b0);
        chk("zero_layer_latency", done_cyc - start_cyc, 2);
        chk("zero_layer_issues", n_acc - base, 0);
        chk("underflow_cleared", err_underflow, 0);

        // Table cleared by reset: one zero-row layer passes straight through.
        do_start(1, 1'b1);
        wait_done(6, 40, 1'b0);
        chk("empty_layer_issues", n_acc - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dense_layer_scheduler.md
Name: dense_layer_scheduler

Overview:
- Sequences the dense-layer datapath for inference and training.
- Walks layers and weight rows in order: forward pass layers 0..N-1, then, in train mode only, backward pass layers N-1..0.
- Issues one row operation per accepted cycle into the dense-layer delay/compute pipeline.
- Tracks in-flight operations so each layer drains before the next dependent layer starts.

Parameters:
- max_layers, 8, depth of the per-layer row-count table.
- row_w, 16, width of row counters and row-count entries.
- max_inflight, 15, maximum outstanding ops; sized ≥ pipeline latency.
- dense_type_size, 4, width of dense_type field.
- act_type_size, 4, width of act_type field.
- cost_type_size, 8, width of cost_type field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for row-count table; accepted only in IDLE.
- cfg_addr  in  $clog2(max_layers)  layer index for table write.
- cfg_rows  in  row_w  row count of that layer.
- num_layers  in  $clog2(max_layers)+1  layers to run; sampled on start.
- train  in  1  1 = forward + backward/update; 0 = forward only. Sampled on start.
- act_type  in  act_type_size  passed to issue bundle; sampled on start.
- cost_type  in  cost_type_size  passed to issue bundle; sampled on start.
- start  in  1  single-cycle pulse; ignored unless state is IDLE.
- issue_valid  out  1  row operation presented.
- issue_ready  in  1  downstream accepts the operation.
- w_layer_index  out  32  current layer, zero-extended.
- w_row_index  out  32  current row, zero-extended.
- dense_type  out  dense_type_size  FWD=0, BWD=1 (package constants).
- is_update  out  1  1 on backward issues when train=1.
- backprop_cost  out  1  1 on backward issues of layer N-1 only.
- is_cost_layer  out  1  1 on forward issues of layer N-1 when train=1.
- act_type_out, cost_type_out  out  as inputs  latched copies.
- result_valid  in  1  one completed op returned by the pipeline.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse on the final drain completion.
- err_underflow  out  1  sticky; set when result_valid arrives with inflight==0; cleared on start.

Behaviour:
- Reset: state IDLE. All outputs 0: issue_valid, indices, flags, busy, done, err_underflow, inflight. Row-count table cleared to 0.
- A reset mid-operation aborts immediately. Later result_valid pulses with inflight==0 set err_underflow.
- States:
  - IDLE: on start, latch inputs; layer=0, row=0; go to FWD. If num_layers==0, go to DONE instead.
  - FWD: issue_valid=1 while row<rows[layer] and inflight<max_inflight. On valid&ready, row++. After the last row of a layer is accepted, go to DRAIN_F.
  - DRAIN_F: issue_valid=0; wait inflight==0.
    - If layer<N-1: layer++, row=0, back to FWD.
    - Else if train: layer=N-1, row=0, go to BWD.
    - Else: go to DONE.
  - BWD: same issue rule as FWD, with BWD flags; then DRAIN_B.
  - DRAIN_B: wait inflight==0. If layer>0: layer--, back to BWD. Else go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Layers with rows==0 pass straight through FWD/BWD to drain: no issue, drain satisfied in 1 cycle.
- Outputs are registered. Fields hold stable while issue_valid=1 and ready=0, and change only after acceptance.
- Inflight counter:
  - +1 on accept; −1 on result_valid; accept and result in the same cycle leaves it unchanged.
  - Never exceeds max_inflight, because issue stalls at the limit.
  - Never goes below 0: underflow saturates at 0 and sets err_underflow.
- Row-count table writes during busy are dropped.

Decomposition:
- Package dense_sched_pkg: state enum (IDLE, FWD, DRAIN_F, BWD, DRAIN_B, DONE) and DENSE_FWD/DENSE_BWD constants.
- Sub-module inflight_counter (params max_inflight). Ports: inc, dec, count, full, empty, underflow.

Test Plan:
- cfg rows={3,2}, num_layers=2, train=0, ready=1, results returned 4 cycles after issue → issues (0,0),(0,1),(0,2); none until 3 results return; then (1,0),(1,1); done pulse once; is_cost_layer=0 throughout.
- Same config, train=1 → forward as above with is_cost_layer=1 on layer-1 issues. Backward order (1,0),(1,1),(0,0..2); backprop_cost=1 only on layer 1; is_update=1 on all backward issues.
- ready toggling 0/1 every cycle → fields stable while stalled; no skipped or duplicate rows; total issues = 5 (fwd) or 10 (train).
- max_inflight=2, results withheld → issue_valid drops after 2 accepts. Result with accept in the same cycle → count stays 2.
- num_layers=0 start → done exactly 2 cycles after start, no issue_valid. Start asserted while busy → ignored.
- Reset asserted mid-FWD with 3 in flight → all outputs 0 next cycle. Subsequent result_valid → err_underflow=1. Next start → err_underflow cleared.
